// File: rtl/seq_ctrl_if.sv
// Handshake and memory-control bundle between a host and the seq_ctrl sequencer.
// The host (master) drives START/IN_VALID; the sequencer (slave) drives everything else.
interface seq_ctrl_if;
  logic       START;
  logic       IN_VALID;
  logic       IN_READY;
  logic [2:0] ADDR_A;
  logic       WE_A;
  logic       LD_D2;
  logic [1:0] ADDR_B;
  logic       WE_B;
  logic       BUSY;
  logic       DONE;

  modport master (
    output START, IN_VALID,
    input  IN_READY, ADDR_A, WE_A, LD_D2, ADDR_B, WE_B, BUSY, DONE
  );

  modport slave (
    input  START, IN_VALID,
    output IN_READY, ADDR_A, WE_A, LD_D2, ADDR_B, WE_B, BUSY, DONE
  );
endinterface

// File: rtl/seq_ctrl.sv
// Load/compute sequencer: writes 8 input bytes into A-memory, then pairs them up
// (A[2k], A[2k+1]) through the datapath into B[k], finishing with a one-cycle DONE.
module seq_ctrl (
  input  logic       CLK,
  input  logic       RESET,
  seq_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StRdEven,
    StRdOdd,
    StFin
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] addr_a_q, addr_a_d;
  logic [1:0] addr_b_q, addr_b_d;

  logic in_ready, we_a, ld_d2, we_b, busy, done;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= StIdle;
      addr_a_q <= 3'd0;
      addr_b_q <= 2'd0;
    end else begin
      state_q  <= state_d;
      addr_a_q <= addr_a_d;
      addr_b_q <= addr_b_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_a_d = addr_a_q;
    addr_b_d = addr_b_q;
    in_ready = 1'b0;
    we_a     = 1'b0;
    ld_d2    = 1'b0;
    we_b     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.START) begin
          state_d  = StLoad;
          addr_a_d = 3'd0;
          addr_b_d = 2'd0;
        end
      end
      StLoad: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        we_a     = bus.IN_VALID;
        if (bus.IN_VALID) begin
          addr_a_d = addr_a_q + 3'd1;
          if (addr_a_q == 3'd7) begin
            state_d = StRdEven;
          end
        end
      end
      StRdEven: begin
        busy     = 1'b1;
        ld_d2    = 1'b1;
        addr_a_d = addr_a_q + 3'd1;
        state_d  = StRdOdd;
      end
      StRdOdd: begin
        busy     = 1'b1;
        we_b     = 1'b1;
        addr_a_d = addr_a_q + 3'd1;
        addr_b_d = addr_b_q + 2'd1;
        state_d  = (addr_b_q == 2'd3) ? StFin : StRdEven;
      end
      StFin: begin
        busy     = 1'b1;
        done     = 1'b1;
        addr_a_d = 3'd0;
        addr_b_d = 2'd0;
        state_d  = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Reset masks every strobe immediately, before the state register clears.
    if (!RESET) begin
      in_ready = 1'b0;
      we_a     = 1'b0;
      ld_d2    = 1'b0;
      we_b     = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
    end
  end

  assign bus.IN_READY = in_ready;
  assign bus.WE_A     = we_a;
  assign bus.LD_D2    = ld_d2;
  assign bus.WE_B     = we_b;
  assign bus.BUSY     = busy;
  assign bus.DONE     = done;
  assign bus.ADDR_A   = addr_a_q;
  assign bus.ADDR_B   = addr_b_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Bench for seq_ctrl: a phase/count model predicts every output each cycle, and
// directed runs pin latency, B-write order and A-memory contents with literal values.
module tb_seq_ctrl;

  logic CLK;
  logic RESET;
  logic [7:0] wdata;

  seq_ctrl_if bus ();

  seq_ctrl dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [7:0] pat   [8];
  logic [7:0] mem_a [8];
  int done_q[$];
  int web_q[$];

  // Model: phase 0 idle, 1 loading (m_nload bytes taken), 2 computing (step 0..7), 3 finishing.
  int m_phase = 0;
  int m_nload = 0;
  int m_step  = 0;
  bit m_valid = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
  endtask

  always @(posedge CLK) cyc++;

  always @(posedge CLK) begin
    if (!RESET) begin
      m_phase = 0;
      m_nload = 0;
      m_step  = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      case (m_phase)
        0: if (bus.START) begin m_phase = 1; m_nload = 0; end
        1: if (bus.IN_VALID) begin
             m_nload++;
             if (m_nload == 8) begin m_phase = 2; m_step = 0; end
           end
        2: begin
             m_step++;
             if (m_step == 8) m_phase = 3;
           end
        default: m_phase = 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    int ea, eb, ir, bz, dn, wa, wb, ld;
    if (m_valid) begin
      ea = 0; eb = 0; ir = 0; bz = 0; dn = 0; wa = 0; wb = 0; ld = 0;
      case (m_phase)
        1: begin ir = 1; bz = 1; wa = int'(bus.IN_VALID); ea = m_nload; end
        2: begin bz = 1; ld = int'(m_step % 2 == 0); wb = int'(m_step % 2 == 1);
                 ea = m_step; eb = m_step / 2; end
        3: begin bz = 1; dn = 1; end
        default: ;
      endcase
      if (!RESET) begin ir = 0; bz = 0; dn = 0; wa = 0; wb = 0; ld = 0; end
      check("outputs", int'({bus.IN_READY, bus.BUSY, bus.DONE, bus.WE_A, bus.WE_B, bus.LD_D2,
                             bus.ADDR_A, bus.ADDR_B}),
            (ir << 10) | (bz << 9) | (dn << 8) | (wa << 7) | (wb << 6) | (ld << 5) |
            (ea << 2) | eb);
      check("strobe_exclusive", int'(bus.WE_A) + int'(bus.WE_B) + int'(bus.LD_D2) <= 1, 1);
      if (bus.DONE) done_q.push_back(cyc);
      if (bus.WE_B) web_q.push_back(int'(bus.ADDR_B));
      if (bus.WE_A) mem_a[bus.ADDR_A] = wdata;
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_done(input int nd);
    for (int k = 0; k < 60 && done_q.size() == nd; k++) step();
  endtask

  task automatic do_run(input int stall_at, input int stall_len, input int exp_lat);
    int t0, nd;
    nd = done_q.size();
    web_q.delete();
    for (int i = 0; i < 8; i++) mem_a[i] = 8'hxx;
    bus.START = 1'b1;
    t0 = cyc;
    step();
    bus.START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == stall_at) begin
        bus.IN_VALID = 1'b0;
        for (int j = 0; j < stall_len; j++) begin
          #1;
          check("stall_addr_a", int'(bus.ADDR_A), i);
          check("stall_we_a", int'(bus.WE_A), 0);
          step();
        end
      end
      bus.IN_VALID = 1'b1;
      wdata = pat[i];
      step();
    end
    bus.IN_VALID = 1'b0;
    wait_done(nd);
    if (done_q.size() == nd) check("done_timeout", 0, 1);
    else check("done_latency", done_q[nd] - t0, exp_lat);
    check("web_count", web_q.size(), 4);
    for (int k = 0; k < web_q.size(); k++) check("web_addr", web_q[k], k);
    for (int i = 0; i < 8; i++) check("mem_a", int'(mem_a[i]), int'(pat[i]));
    step();
  endtask

  initial begin
    int t0, nd;
    pat[0] = 8'd10; pat[1] = 8'd3; pat[2] = 8'd7; pat[3] = 8'd9;
    pat[4] = 8'd20; pat[5] = 8'd5; pat[6] = 8'd1; pat[7] = 8'd4;
    RESET = 1'b0;
    bus.START = 1'b0;
    bus.IN_VALID = 1'b0;
    wdata = 8'd0;

    // Reset then idle
    step();
    step();
    RESET = 1'b1;
    #1;
    check("rst_addr_a", int'(bus.ADDR_A), 0);
    check("rst_addr_b", int'(bus.ADDR_B), 0);
    check("rst_busy", int'(bus.BUSY), 0);
    check("rst_in_ready", int'(bus.IN_READY), 0);
    check("rst_done", int'(bus.DONE), 0);
    repeat (3) step();

    // Full run, then a run stalled for 3 cycles after the 2nd byte
    do_run(-1, 0, 17);
    do_run(2, 3, 20);

    // START held high for 40 cycles: two complete runs fit, a third is cut by reset
    nd = done_q.size();
    t0 = cyc;
    bus.START = 1'b1;
    bus.IN_VALID = 1'b1;
    wdata = 8'h5a;
    repeat (40) step();
    bus.START = 1'b0;
    bus.IN_VALID = 1'b0;
    check("held_done_pulses", done_q.size() - nd, 2);
    if (done_q.size() >= nd + 2) begin
      check("held_done1", done_q[nd] - t0, 17);
      check("held_done2", done_q[nd + 1] - t0, 35);
    end
    RESET = 1'b0;
    step();
    RESET = 1'b1;
    step();

    // Reset during the RD_ODD cycle with ADDR_B=1
    nd = done_q.size();
    bus.START = 1'b1;
    step();
    bus.START = 1'b0;
    bus.IN_VALID = 1'b1;
    for (int i = 0; i < 8; i++) begin wdata = pat[i]; step(); end
    bus.IN_VALID = 1'b0;
    repeat (3) step();
    RESET = 1'b0;
    #1;
    check("abort_we_b", int'(bus.WE_B), 0);
    check("abort_addr_b", int'(bus.ADDR_B), 1);
    check("abort_busy", int'(bus.BUSY), 0);
    step();
    RESET = 1'b1;
    #1;
    check("abort_idle_busy", int'(bus.BUSY), 0);
    check("abort_idle_addr_a", int'(bus.ADDR_A), 0);
    repeat (20) step();
    check("abort_no_done", done_q.size() - nd, 0);
    do_run(-1, 0, 17);

    repeat (2) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
